// File: rtl/man_align_shift.sv
// Alignment stage of the FP add/sub datapath: right-shifts the smaller mantissa
// STEP bits per cycle, collecting guard/round/sticky, then hands the pair downstream.
module man_align_shift #(
   parameter int SIZE_MAN = 24,
   parameter int SIZE_EXP = 8,
   parameter int STEP     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_sign_max,
   input  logic                  i_sign_min,
   input  logic [SIZE_MAN-1:0]   i_man_max,
   input  logic [SIZE_MAN-1:0]   i_man_min,
   input  logic [SIZE_EXP-1:0]   i_exp_diff,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_sign_max,
   output logic                  o_sign_min,
   output logic                  o_eff_sub,
   output logic [SIZE_MAN-1:0]   o_man_max,
   output logic [SIZE_MAN+2:0]   o_man_min_al,
   output logic [1:0]            o_state
);

   localparam int EXT_W = SIZE_MAN + 2;
   localparam int CNT_W = $clog2(EXT_W + 1);
   localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] CLAMP_C = CNT_W'(EXT_W);
   localparam logic [31:0]      CLAMP_W = 32'(EXT_W);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; the producer holds data stable while valid is high and ready low.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state;
   logic                 valid_q;
   logic [EXT_W-1:0]     ext;
   logic                 sticky;
   logic [CNT_W-1:0]     rem;
   logic                 sign_max;
   logic                 sign_min;
   logic [SIZE_MAN-1:0]  man_max;

   logic [31:0]          diff_wide;
   logic [CNT_W-1:0]     diff_clamped;
   logic [CNT_W-1:0]     k;
   logic                 lost;
   logic [EXT_W-1:0]     ext_next;
   logic [CNT_W-1:0]     rem_next;

   // Any shift of EXT_W or more leaves ext empty, so clamping is exact.
   assign diff_wide = 32'(i_exp_diff);

   always_comb begin
      diff_clamped = diff_wide[CNT_W-1:0];
      if (diff_wide > CLAMP_W) begin
         diff_clamped = CLAMP_C;
      end
   end

   always_comb begin
      k = rem;
      if (rem > STEP_C) begin
         k = STEP_C;
      end
      lost = 1'b0;
      for (int i = 0; i < EXT_W; i++) begin
         if (i < int'(k)) begin
            lost = lost | ext[i];
         end
      end
      ext_next = ext >> k;
      rem_next = rem - k;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         valid_q  <= 1'b0;
         ext      <= '0;
         sticky   <= 1'b0;
         rem      <= '0;
         sign_max <= 1'b0;
         sign_min <= 1'b0;
         man_max  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  sign_max <= i_sign_max;
                  sign_min <= i_sign_min;
                  man_max  <= i_man_max;
                  ext      <= {i_man_min, 2'b00};
                  sticky   <= 1'b0;
                  rem      <= diff_clamped;
                  if (diff_clamped == '0) begin
                     state   <= DONE;
                     valid_q <= 1'b1;
                  end else begin
                     state   <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               ext    <= ext_next;
               sticky <= sticky | lost;
               rem    <= rem_next;
               if (rem_next == '0) begin
                  state   <= DONE;
                  valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (i_ready) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready      = (state == IDLE) && !i_rst;
   assign o_valid      = valid_q;
   assign o_sign_max   = sign_max;
   assign o_sign_min   = sign_min;
   assign o_eff_sub    = sign_max ^ sign_min;
   assign o_man_max    = man_max;
   assign o_man_min_al = {ext, sticky};
   assign o_state      = state;

endmodule

// File: tb/tb_man_align_shift.sv
// Bench for man_align_shift: directed cases plus random operations checked
// against an arithmetic model of the alignment.
module tb_man_align_shift;

   localparam int SM = 24;
   localparam int SE = 8;
   localparam int ST = 4;
   localparam int EW = SM + 2;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic          i_sign_max = 1'b0;
   logic          i_sign_min = 1'b0;
   logic [SM-1:0] i_man_max = '0;
   logic [SM-1:0] i_man_min = '0;
   logic [SE-1:0] i_exp_diff = '0;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic          o_sign_max;
   logic          o_sign_min;
   logic          o_eff_sub;
   logic [SM-1:0] o_man_max;
   logic [SM+2:0] o_man_min_al;
   logic [1:0]    o_state;

   int n_vec = 0;
   int n_err = 0;

   man_align_shift #(.SIZE_MAN(SM), .SIZE_EXP(SE), .STEP(ST)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_sign_max(i_sign_max), .i_sign_min(i_sign_min),
      .i_man_max(i_man_max), .i_man_min(i_man_min), .i_exp_diff(i_exp_diff),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_sign_max(o_sign_max), .o_sign_min(o_sign_min), .o_eff_sub(o_eff_sub),
      .o_man_max(o_man_max), .o_man_min_al(o_man_min_al), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Exact right shift of {man,00} by the clamped distance; sticky is "anything fell off".
   function automatic logic [SM+2:0] ref_align(input logic [SM-1:0] mn, input logic [SE-1:0] diff);
      int          dc;
      logic [63:0] v;
      logic [63:0] sh;
      logic        lost;
      dc   = (int'(diff) > EW) ? EW : int'(diff);
      v    = {40'd0, mn} << 2;
      sh   = v >> dc;
      lost = (v & ((64'd1 << dc) - 64'd1)) != 64'd0;
      return {sh[EW-1:0], lost};
   endfunction

   function automatic int ref_latency(input logic [SE-1:0] diff);
      int dc;
      dc = (int'(diff) > EW) ? EW : int'(diff);
      return 1 + (dc + ST - 1) / ST;
   endfunction

   task automatic scramble_inputs();
      i_sign_max = 1'($urandom);
      i_sign_min = 1'($urandom);
      i_man_max  = SM'($urandom);
      i_man_min  = SM'($urandom);
      i_exp_diff = SE'($urandom);
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!o_ready && t < 200) begin
         @(negedge i_clk);
         t++;
      end
      check("ready_idle", 64'(o_ready), 64'd1);
   endtask

   task automatic do_op(input logic [SE-1:0] diff, input logic [SM-1:0] mn, input logic [SM-1:0] mx,
                        input logic sm, input logic sn, input int hold);
      logic [SM+2:0] exp_al;
      int            exp_lat;
      int            lat;
      exp_al  = ref_align(mn, diff);
      exp_lat = ref_latency(diff);
      wait_ready();
      i_valid = 1'b1; i_exp_diff = diff; i_man_min = mn; i_man_max = mx;
      i_sign_max = sm; i_sign_min = sn;
      @(negedge i_clk);
      i_valid = 1'b0;
      scramble_inputs();
      lat = 1;
      while (!o_valid && lat < 100) begin
         check("ready_busy", 64'(o_ready), 64'd0);
         @(negedge i_clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("man_min_al", 64'(o_man_min_al), 64'(exp_al));
      check("man_max", 64'(o_man_max), 64'(mx));
      check("sign_max", 64'(o_sign_max), 64'(sm));
      check("sign_min", 64'(o_sign_min), 64'(sn));
      check("eff_sub", 64'(o_eff_sub), 64'(sm ^ sn));
      for (int h = 0; h < hold; h++) begin
         i_valid = 1'b1;
         scramble_inputs();
         @(negedge i_clk);
         check("hold_valid", 64'(o_valid), 64'd1);
         check("hold_ready", 64'(o_ready), 64'd0);
         check("hold_al", 64'(o_man_min_al), 64'(exp_al));
         check("hold_max", 64'(o_man_max), 64'(mx));
         check("hold_eff", 64'(o_eff_sub), 64'(sm ^ sn));
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      check("valid_drop", 64'(o_valid), 64'd0);
      check("ready_back", 64'(o_ready), 64'd1);
   endtask

   initial begin
      logic [SE-1:0] d;
      logic [SM-1:0] mn;

      repeat (3) @(negedge i_clk);
      check("rst_ready", 64'(o_ready), 64'd0);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_al", 64'(o_man_min_al), 64'd0);
      check("rst_max", 64'(o_man_max), 64'd0);
      check("rst_signs", 64'({o_sign_max, o_sign_min, o_eff_sub}), 64'd0);
      check("rst_state", 64'(o_state), 64'd0);
      i_rst = 1'b0;
      @(negedge i_clk);

      do_op(8'd0,   24'hC00000, 24'h123456, 1'b0, 1'b0, 0);
      do_op(8'd1,   24'h800001, 24'hABCDEF, 1'b0, 1'b1, 0);
      do_op(8'd5,   24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 0);
      do_op(8'd200, 24'h800000, 24'h800000, 1'b1, 1'b0, 0);
      do_op(8'd25,  24'h800000, 24'h900000, 1'b0, 1'b0, 0);
      do_op(8'd26,  24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1);
      do_op(8'd9,   24'h000000, 24'h800000, 1'b0, 1'b0, 0);
      do_op(8'd3,   24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b0, 3);

      // Reset during the second SHIFT cycle of a 20-bit alignment.
      wait_ready();
      i_valid = 1'b1; i_exp_diff = 8'd20; i_man_min = 24'hFFFFFF; i_man_max = 24'h777777;
      i_sign_max = 1'b1; i_sign_min = 1'b0;
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b1;
      check("midrst_ready", 64'(o_ready), 64'd0);
      @(negedge i_clk);
      check("midrst_state", 64'(o_state), 64'd0);
      check("midrst_valid", 64'(o_valid), 64'd0);
      check("midrst_al", 64'(o_man_min_al), 64'd0);
      check("midrst_max", 64'(o_man_max), 64'd0);
      check("midrst_signs", 64'({o_sign_max, o_sign_min, o_eff_sub}), 64'd0);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("postrst_valid", 64'(o_valid), 64'd0);
      do_op(8'd0, 24'h8F0F0F, 24'hF0F0F0, 1'b0, 1'b1, 0);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: d = SE'($urandom_range(0, 8));
            1: d = SE'($urandom_range(0, 30));
            2: d = SE'($urandom_range(22, 28));
            default: d = SE'($urandom);
         endcase
         mn = SM'($urandom) | 24'h800000;
         if ($urandom_range(0, 9) == 0) mn = '0;
         do_op(d, mn, SM'($urandom) | 24'h800000, 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
